// File: rtl/boton_antirrebote_pkg.sv
// Shared types and defaults for the push-button debouncer.
package boton_antirrebote_pkg;

    typedef enum logic [1:0] {
        ST_IDLE_LOW  = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_IDLE_HIGH = 2'd2,
        ST_WAIT_LOW  = 2'd3
    } state_t;

    // 10 ms at 50 MHz
    localparam int STABLE_CYCLES_DEF = 500000;
    localparam int SYNC_STAGES_DEF   = 2;

    typedef struct packed {
        logic       level;
        logic       rise;
        logic       fall;
        logic [7:0] count;
    } status_t;

endpackage

// File: rtl/boton_antirrebote_if.sv
// Button-side bundle: raw pin in, debounced level, strobes and press counter out.
interface boton_antirrebote_if;
    logic       btn_in;
    logic       level_out;
    logic       rise_pulse;
    logic       fall_pulse;
    logic [7:0] press_count;

    modport master (input btn_in, output level_out, rise_pulse, fall_pulse, press_count);
    modport slave  (output btn_in, input level_out, rise_pulse, fall_pulse, press_count);
endinterface

// File: rtl/boton_antirrebote_sincronizador.sv
// Multi-flop synchronizer for an asynchronous single-bit input; reusable for other board pins.
module sincronizador #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ff <= {STAGES{RST_VAL}};
        else        ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];
endmodule

// File: rtl/boton_antirrebote.sv
// Debouncer: synchronizer + stability window FSM, registered level, edge strobes and press count.
module boton_antirrebote
    import boton_antirrebote_pkg::*;
#(
    parameter int STABLE_CYCLES  = STABLE_CYCLES_DEF,
    parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
    parameter bit BTN_ACTIVE_LOW = 1'b0
) (
    input logic                  clk,
    input logic                  rst_n,
    boton_antirrebote_if.master  bus
);
    localparam int             CW       = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic          sync_q, s;
    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    status_t       st, st_nxt;
    logic          commit_hi, commit_lo;

    // Reset value is the idle (not pressed) pin level so no false edge follows reset
    sincronizador #(.STAGES(SYNC_STAGES), .RST_VAL(BTN_ACTIVE_LOW)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.btn_in),
        .q     (sync_q)
    );

    assign s = sync_q ^ BTN_ACTIVE_LOW;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE_LOW;
            cnt   <= '0;
            st    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            st    <= st_nxt;
        end
    end

    // Any opposite sample while waiting aborts the window and discards the count
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE_LOW: if (s) begin
                state_nxt = ST_WAIT_HIGH;
                cnt_nxt   = CW'(1);
            end
            ST_WAIT_HIGH: begin
                if (!s) begin
                    state_nxt = ST_IDLE_LOW;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_IDLE_HIGH;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + CW'(1);
                end
            end
            ST_IDLE_HIGH: if (!s) begin
                state_nxt = ST_WAIT_LOW;
                cnt_nxt   = CW'(1);
            end
            ST_WAIT_LOW: begin
                if (s) begin
                    state_nxt = ST_IDLE_HIGH;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_IDLE_LOW;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE_LOW;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        commit_hi    = (state == ST_WAIT_HIGH) && (state_nxt == ST_IDLE_HIGH);
        commit_lo    = (state == ST_WAIT_LOW)  && (state_nxt == ST_IDLE_LOW);
        st_nxt       = st;
        st_nxt.rise  = commit_hi;
        st_nxt.fall  = commit_lo;
        if (commit_hi) st_nxt.level = 1'b1;
        else if (commit_lo) st_nxt.level = 1'b0;
        st_nxt.count = st.count + {7'd0, commit_hi};
    end

    assign bus.level_out   = st.level;
    assign bus.rise_pulse  = st.rise;
    assign bus.fall_pulse  = st.fall;
    assign bus.press_count = st.count;
endmodule

// File: tb/tb_boton_antirrebote.sv
// Bench for boton_antirrebote: vector table plus pulse scoreboard, with reset/wrap/polarity sequences.
module tb_boton_antirrebote;
    localparam int STABLE = 4;
    localparam int SYNC   = 2;
    // drive after edge k -> edge 0 is k+1 -> level/pulse at k+1+SYNC+STABLE-1
    localparam int OFS    = SYNC + STABLE;

    logic clk = 1'b0;
    logic rst_n;
    int   edge_n = 0;
    int   n_chk = 0, n_pass = 0;
    int   n_rise = 0, n_fall = 0;

    boton_antirrebote_if bus0 ();
    boton_antirrebote_if bus1 ();

    boton_antirrebote #(.STABLE_CYCLES(STABLE), .SYNC_STAGES(SYNC), .BTN_ACTIVE_LOW(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    boton_antirrebote #(.STABLE_CYCLES(STABLE), .SYNC_STAGES(SYNC), .BTN_ACTIVE_LOW(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        logic       btn;
        int         hold;
        logic       exp_level;
        int         exp_count;
        logic [1:0] pulse;   // 1 = rise expected, 2 = fall expected
    } vec_t;

    typedef struct {
        int at;
        bit rise;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit rise);
        exp_t e;
        e.at   = edge_n + OFS;
        e.rise = rise;
        exp_q.push_back(e);
    endtask

    function automatic vec_t mk(input logic b, input int h, input logic l, input int c, input logic [1:0] p);
        vec_t v;
        v.btn = b; v.hold = h; v.exp_level = l; v.exp_count = c; v.pulse = p;
        return v;
    endfunction

    // Scoreboard: every observed strobe must match the oldest pending expectation
    always @(negedge clk) begin
        exp_t e;
        if (bus0.rise_pulse || bus0.fall_pulse) begin
            if (bus0.rise_pulse) n_rise++;
            if (bus0.fall_pulse) n_fall++;
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL pulse_unexpected: rise=%0b fall=%0b at edge %0d, none expected",
                         bus0.rise_pulse, bus0.fall_pulse, edge_n);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_edge", edge_n, e.at);
                chk("pulse_rise", int'(bus0.rise_pulse), int'(e.rise));
                chk("pulse_fall", int'(bus0.fall_pulse), int'(!e.rise));
            end
        end else if (exp_q.size() > 0 && exp_q[0].at < edge_n) begin
            e = exp_q.pop_front();
            n_chk++;
            $display("FAIL pulse_missing: strobe rise=%0b due at edge %0d not observed (now %0d)",
                     e.rise, e.at, edge_n);
        end
    end

    initial begin
        int r0, f0;
        // bounce pattern first, then clean edges, windows one short of and exactly STABLE
        foreach (vecs[i]) ;
        vecs.push_back(mk(1, 1, 0, 0, 0)); vecs.push_back(mk(1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0)); vecs.push_back(mk(0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0)); vecs.push_back(mk(1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0)); vecs.push_back(mk(0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0)); vecs.push_back(mk(0, 10, 0, 0, 0));
        vecs.push_back(mk(1, 20, 1, 1, 1)); vecs.push_back(mk(0, 20, 0, 1, 2));
        vecs.push_back(mk(1, 3, 0, 1, 0));  vecs.push_back(mk(0, 10, 0, 1, 0));
        vecs.push_back(mk(1, 4, 0, 1, 1));  vecs.push_back(mk(0, 20, 0, 2, 2));
        vecs.push_back(mk(1, 20, 1, 3, 1)); vecs.push_back(mk(0, 3, 1, 3, 0));
        vecs.push_back(mk(1, 10, 1, 3, 0)); vecs.push_back(mk(0, 20, 0, 3, 2));

        // reset held with the pin pressed: everything stays 0
        rst_n = 1'b0;
        bus0.btn_in = 1'b1;
        bus1.btn_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_hold_status", {bus0.level_out, bus0.rise_pulse, bus0.fall_pulse, bus0.press_count}, 0);
        end
        rst_n = 1'b1;
        push(1);
        tick();
        tick();
        chk("rst_rel_level_early", bus0.level_out, 0);
        repeat (18) tick();
        chk("rst_rel_level", bus0.level_out, 1);
        chk("rst_rel_count", bus0.press_count, 1);
        bus0.btn_in = 1'b0;
        push(0);
        repeat (20) tick();
        chk("rst_rel_fall_level", bus0.level_out, 0);
        chk("rst_rel_fall_count", bus0.press_count, 1);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("rerst_count", bus0.press_count, 0);

        foreach (vecs[i]) begin
            bus0.btn_in = vecs[i].btn;
            if (vecs[i].pulse == 2'd1) push(1);
            else if (vecs[i].pulse == 2'd2) push(0);
            repeat (vecs[i].hold) tick();
            chk($sformatf("vec%0d_level", i), bus0.level_out, vecs[i].exp_level);
            chk($sformatf("vec%0d_count", i), bus0.press_count, vecs[i].exp_count);
        end

        // reset in the middle of a wait window
        bus0.btn_in = 1'b1;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("midwait_rst_status", {bus0.level_out, bus0.rise_pulse, bus0.fall_pulse, bus0.press_count}, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        push(1);
        repeat (OFS - 1) tick();
        chk("midwait_level_edge5", bus0.level_out, 0);
        tick();
        chk("midwait_level_edge6", bus0.level_out, 1);
        chk("midwait_count", bus0.press_count, 1);
        repeat (10) tick();

        // reset while pressed: level drops with no fall strobe
        rst_n = 1'b0;
        bus0.btn_in = 1'b0;
        #1;
        chk("hi_rst_level", bus0.level_out, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        chk("hi_rst_level_after", bus0.level_out, 0);

        // 256 presses wrap the counter back to 0
        r0 = n_rise;
        f0 = n_fall;
        for (int i = 0; i < 256; i++) begin
            bus0.btn_in = 1'b1;
            push(1);
            repeat (8) tick();
            if (i == 254) chk("wrap_count_255", bus0.press_count, 255);
            bus0.btn_in = 1'b0;
            push(0);
            repeat (8) tick();
        end
        repeat (4) tick();
        chk("wrap_count", bus0.press_count, 0);
        chk("wrap_rises", n_rise - r0, 256);
        chk("wrap_falls", n_fall - f0, 256);

        // active-low pin on the second instance
        chk("pol_idle_level", bus1.level_out, 0);
        bus1.btn_in = 1'b0;
        repeat (OFS - 1) tick();
        chk("pol_level_edge5", bus1.level_out, 0);
        tick();
        chk("pol_level_edge6", bus1.level_out, 1);
        chk("pol_rise", bus1.rise_pulse, 1);
        chk("pol_count", bus1.press_count, 1);
        tick();
        chk("pol_rise_one_cycle", bus1.rise_pulse, 0);
        bus1.btn_in = 1'b1;
        repeat (20) tick();
        chk("pol_release_level", bus1.level_out, 0);
        chk("pol_release_count", bus1.press_count, 1);

        chk("pending_pulses", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
